// File: rtl/ndp_pkg.sv
// ndp_pkg: shared derivations, state encoding and width helper for the NDP result drain
package ndp_pkg;
  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;
  function automatic int n_elems(input int aw, input int ah, input int sw, input int sh);
    return aw * ah * sw * sh;
  endfunction
  function automatic int n_words(input int ne, input int w, input int ow);
    return ne * w / ow;
  endfunction
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/ndp_relu_slice.sv
// ndp_relu_slice: zeroes one negative WIDTH-bit element when enabled, otherwise passes it through
// ports: i_d element in, o_d element out
module ndp_relu_slice #(
  parameter int WIDTH    = 16,
  parameter int IS_FLOAT = 1,
  parameter int EN       = 0
) (
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_d
);
  logic w_neg;
  assign w_neg = (IS_FLOAT != 0) ? i_d[WIDTH-1] : ($signed(i_d) < 0);
  assign o_d = (EN != 0 && w_neg) ? '0 : i_d;
endmodule

// File: rtl/ndp_result_drain.sv
// ndp_result_drain: snapshots the core result on calc_done_flag rise and streams it out as OUT_WIDTH words
// ports: clk/reset; calc_done_flag + in_c from the core; out_valid/out_ready/out_data/out_last stream;
//        busy while a snapshot is held, drain_done pulse after the last word, sticky overrun
module ndp_result_drain import ndp_pkg::*; #(
  parameter int WIDTH      = 16,
  parameter int IS_FLOAT   = 1,
  parameter int ARR_WIDTH  = 4,
  parameter int ARR_HEIGHT = 4,
  parameter int SYS_WIDTH  = 64,
  parameter int SYS_HEIGHT = 1,
  parameter int OUT_WIDTH  = 32,
  parameter int APPLY_RELU = 0
) (
  input  logic                                                                    clk,
  input  logic                                                                    reset,
  input  logic                                                                    calc_done_flag,
  input  logic [n_elems(ARR_WIDTH, ARR_HEIGHT, SYS_WIDTH, SYS_HEIGHT)*WIDTH-1:0] in_c,
  output logic                                                                    out_valid,
  input  logic                                                                    out_ready,
  output logic [OUT_WIDTH-1:0]                                                    out_data,
  output logic                                                                    out_last,
  output logic                                                                    busy,
  output logic                                                                    drain_done,
  output logic                                                                    overrun
);
  localparam int N_ELEMS = n_elems(ARR_WIDTH, ARR_HEIGHT, SYS_WIDTH, SYS_HEIGHT);
  localparam int N_WORDS = n_words(N_ELEMS, WIDTH, OUT_WIDTH);
  localparam int IW      = clog2(N_WORDS);
  localparam int EPW     = OUT_WIDTH / WIDTH;
  localparam logic [IW-1:0] LAST = IW'(N_WORDS - 1);
  state_t                    r_state;
  logic                      r_done_q;
  logic [N_ELEMS*WIDTH-1:0]  r_snap;
  logic [IW-1:0]             r_idx;
  logic                      r_valid;
  logic                      r_busy;
  logic                      r_drain_done;
  logic                      r_overrun;
  logic                      w_start;
  logic                      w_is_last;
  logic [OUT_WIDTH-1:0]      w_words [N_WORDS];
  logic [OUT_WIDTH-1:0]      w_word;
  assign w_start   = calc_done_flag & ~r_done_q;
  assign w_is_last = (r_idx == LAST);
  for (genvar w = 0; w < N_WORDS; w++) begin : g_word
    assign w_words[w] = r_snap[w*OUT_WIDTH +: OUT_WIDTH];
  end
  assign w_word = w_words[r_idx];
  for (genvar e = 0; e < EPW; e++) begin : g_relu
    ndp_relu_slice #(.WIDTH(WIDTH), .IS_FLOAT(IS_FLOAT), .EN(APPLY_RELU)) u_relu (
      .i_d(w_word[e*WIDTH +: WIDTH]),
      .o_d(out_data[e*WIDTH +: WIDTH])
    );
  end
  assign out_valid  = r_valid;
  assign out_last   = r_valid & w_is_last;
  assign busy       = r_busy;
  assign drain_done = r_drain_done;
  assign overrun    = r_overrun;
  // done_q resets high so a flag already asserted across reset release is not seen as a new result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_done_q     <= 1'b1;
      r_snap       <= '0;
      r_idx        <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_drain_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_done_q     <= calc_done_flag;
      r_drain_done <= 1'b0;
      if (r_state == IDLE) begin
        if (w_start) begin
          r_snap  <= in_c;
          r_idx   <= '0;
          r_busy  <= 1'b1;
          r_valid <= 1'b1;
          r_state <= STREAM;
        end
      end else begin
        if (w_start) r_overrun <= 1'b1;
        if (r_valid && out_ready) begin
          if (w_is_last) begin
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_drain_done <= 1'b1;
            r_state      <= IDLE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ndp_result_drain.sv
// tb_ndp_result_drain: directed table-driven check of the result drain with 8 elements / 4 words
module tb_ndp_result_drain;
  localparam int W  = 16;
  localparam int NE = 8;
  typedef struct {
    logic        f;
    logic        r;
    logic        s;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic        eb;
    logic        edn;
  } vec_t;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flag = 1'b0;
  logic          ready = 1'b0;
  logic [NE*W-1:0] in_c = '0;
  logic          v, l, b, dd, ov;
  logic [31:0]   d;
  logic          rv, rl, rb, rdd, rov;
  logic [31:0]   rd;
  int            tests = 0;
  int            fails = 0;
  int            xfers = 0;
  vec_t          tbl[$];
  ndp_result_drain #(.WIDTH(W), .ARR_WIDTH(2), .ARR_HEIGHT(2), .SYS_WIDTH(2), .SYS_HEIGHT(1),
                     .OUT_WIDTH(32), .APPLY_RELU(0)) dut (
    .clk(clk), .reset(reset), .calc_done_flag(flag), .in_c(in_c),
    .out_valid(v), .out_ready(ready), .out_data(d), .out_last(l),
    .busy(b), .drain_done(dd), .overrun(ov)
  );
  ndp_result_drain #(.WIDTH(W), .ARR_WIDTH(2), .ARR_HEIGHT(2), .SYS_WIDTH(2), .SYS_HEIGHT(1),
                     .OUT_WIDTH(32), .APPLY_RELU(1)) dut_r (
    .clk(clk), .reset(reset), .calc_done_flag(flag), .in_c(in_c),
    .out_valid(rv), .out_ready(ready), .out_data(rd), .out_last(rl),
    .busy(rb), .drain_done(rdd), .overrun(rov)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (!reset && v && ready) xfers++;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [NE*W-1:0] inc_vec;
    logic [NE*W-1:0] x;
    for (int i = 0; i < NE; i++) x[i*W +: W] = 16'(i + 1);
    return x;
  endfunction
  function automatic logic [31:0] word(input int k);
    return {16'(2*k + 2), 16'(2*k + 1)};
  endfunction
  function automatic vec_t mk(input logic f, input logic r, input logic s, input int k,
                              input logic el, input logic eb, input logic edn);
    vec_t x;
    x.f = f; x.r = r; x.s = s; x.ev = (k >= 0); x.ed = (k >= 0) ? word(k) : 32'h0;
    x.el = el; x.eb = eb; x.edn = edn;
    return x;
  endfunction
  initial begin
    int x0;
    tbl.push_back(mk(1, 1, 0,  0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0,  1, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0,  2, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0,  3, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, -1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, -1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,  0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0,  1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0,  1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0,  1, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0,  2, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0,  2, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0,  2, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0,  3, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0,  3, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0,  3, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, -1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, -1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0,  0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 1,  1, 0, 1, 0));
    tbl.push_back(mk(1, 1, 1,  2, 0, 1, 0));
    tbl.push_back(mk(1, 1, 1,  3, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1, -1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, -1, 0, 0, 0));
    reset = 1'b1;
    step();
    step();
    chk("rst_valid", 32'(v), 32'h0);
    chk("rst_busy", 32'(b), 32'h0);
    chk("rst_done", 32'(dd), 32'h0);
    chk("rst_overrun", 32'(ov), 32'h0);
    chk("rst_last", 32'(l), 32'h0);
    chk("rst_data", d, 32'h0);
    reset = 1'b0;
    step();
    x0 = 0;
    foreach (tbl[i]) begin
      if (i == 6) x0 = xfers;
      flag  = tbl[i].f;
      ready = tbl[i].r;
      in_c  = tbl[i].s ? '1 : inc_vec();
      step();
      chk($sformatf("row%0d_valid", i), 32'(v), 32'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("row%0d_data", i), d, tbl[i].ed);
      chk($sformatf("row%0d_last", i), 32'(l), 32'(tbl[i].el));
      chk($sformatf("row%0d_busy", i), 32'(b), 32'(tbl[i].eb));
      chk($sformatf("row%0d_done", i), 32'(dd), 32'(tbl[i].edn));
      chk($sformatf("row%0d_overrun", i), 32'(ov), 32'h0);
      if (i == 17) chk("bp_transfers", 32'(xfers - x0), 32'd4);
    end
    in_c = {16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h7FFF, 16'h8000, 16'hBC00, 16'h3C00};
    flag = 1'b1;
    ready = 1'b0;
    step();
    chk("relu_w0", rd, 32'h00003C00);
    chk("norelu_w0", d, 32'hBC003C00);
    ready = 1'b1;
    step();
    chk("relu_w1", rd, 32'h7FFF0000);
    chk("norelu_w1", d, 32'h7FFF8000);
    flag = 1'b0;
    for (int i = 0; i < 20 && b; i++) step();
    chk("relu_drain_end", 32'(b), 32'h0);
    step();
    in_c = inc_vec();
    flag = 1'b1;
    step();
    chk("ovr_w0", d, word(0));
    chk("ovr_before", 32'(ov), 32'h0);
    flag = 1'b0;
    step();
    chk("ovr_w1", d, word(1));
    flag = 1'b1;
    in_c = '1;
    step();
    chk("ovr_set", 32'(ov), 32'h1);
    chk("ovr_w2", d, word(2));
    step();
    chk("ovr_w3", d, word(3));
    chk("ovr_last", 32'(l), 32'h1);
    step();
    chk("ovr_done", 32'(dd), 32'h1);
    chk("ovr_valid_off", 32'(v), 32'h0);
    step();
    step();
    chk("ovr_no_restart", 32'(b), 32'h0);
    chk("ovr_sticky", 32'(ov), 32'h1);
    flag = 1'b0;
    in_c = inc_vec();
    step();
    flag = 1'b1;
    step();
    chk("rm_w0", d, word(0));
    step();
    chk("rm_w1", d, word(1));
    reset = 1'b1;
    step();
    chk("rm_valid", 32'(v), 32'h0);
    chk("rm_busy", 32'(b), 32'h0);
    chk("rm_done", 32'(dd), 32'h0);
    chk("rm_overrun", 32'(ov), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rm_idle%0d_valid", i), 32'(v), 32'h0);
      chk($sformatf("rm_idle%0d_busy", i), 32'(b), 32'h0);
      chk($sformatf("rm_idle%0d_done", i), 32'(dd), 32'h0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ndp_result_drain.md
Name: ndp_result_drain

Overview:
- Downstream neighbour of the NDP core. Consumes the wide `out_c` result vector when `calc_done_flag` rises.
- Snapshots the vector into a local register, then streams it out as OUT_WIDTH-bit words over a valid/ready handshake toward the host/DRAM write path.
- Optional per-element ReLU on the way out.
- Frees the core to be reset and reloaded while draining proceeds.

Parameters:
- WIDTH, 16, bits per result element.
- IS_FLOAT, 1, element format; 1 = sign-magnitude float (MSB is sign), 0 = two's complement.
- ARR_WIDTH, 4, PE columns per systolic array.
- ARR_HEIGHT, 4, PE rows per systolic array.
- SYS_WIDTH, 64, systolic arrays horizontally.
- SYS_HEIGHT, 1, systolic arrays vertically.
- OUT_WIDTH, 32, output word width; must be a multiple of WIDTH.
- APPLY_RELU, 0, 1 = zero any element whose MSB is set before output.
- Derived N_ELEMS = ARR_WIDTH*ARR_HEIGHT*SYS_WIDTH*SYS_HEIGHT.
- Derived N_WORDS = N_ELEMS*WIDTH/OUT_WIDTH (default 512).

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- calc_done_flag, in, 1, level from the core; high while its result is valid.
- in_c, in, N_ELEMS*WIDTH, result vector from the core.
- out_valid, out, 1, out_data holds a valid word.
- out_ready, in, 1, consumer accepts the word this cycle.
- out_data, out, OUT_WIDTH, current output word.
- out_last, out, 1, high with the final word (index N_WORDS-1).
- busy, out, 1, snapshot held / stream in progress.
- drain_done, out, 1, one-cycle pulse after the last word is accepted.
- overrun, out, 1, sticky: a new result arrived while busy.

Behaviour:
- One clock (clk). Reset is synchronous and active-high; all state is updated only on posedge clk.
- Reset values:
  - out_valid, out_last, busy, drain_done, overrun = 0.
  - out_data = 0; word index = 0; state = IDLE.
  - done_q = 1, so a flag already high across reset release does not trigger a drain.
- Edge detect: start = calc_done_flag & ~done_q; done_q <= calc_done_flag every cycle.
- States: IDLE, STREAM.
- IDLE:
  - On start, in the same edge: snapshot <= in_c, index <= 0, busy <= 1, out_valid <= 1, state <= STREAM.
  - First word is visible the cycle after the start edge (latency 1).
- STREAM:
  - out_data = word[index]. Word k = snapshot bits [(k+1)*OUT_WIDTH-1 : k*OUT_WIDTH], so element 0 sits in the low WIDTH bits of word 0.
  - Transfer happens when out_valid & out_ready.
  - Transfer with index < N_WORDS-1: index increments.
  - Transfer with index == N_WORDS-1: out_valid <= 0, busy <= 0, drain_done <= 1 for exactly one cycle, state <= IDLE.
  - While out_valid & ~out_ready: out_data, out_last and index hold stable. No valid withdrawal.
- out_last = out_valid & (index == N_WORDS-1).
- out_data is combinational from snapshot and index; a registered variant must keep identical cycle timing.
- ReLU: applied per WIDTH slice at the output mux when APPLY_RELU=1 and the slice MSB = 1. The snapshot is never modified.
- Simultaneous events:
  - start while in STREAM is ignored (snapshot untouched) and sets overrun <= 1. overrun clears only on reset.
  - start in the same cycle as the final transfer also counts as overrun; the next drain waits for a fresh rising edge.
- Reset mid-stream: aborts immediately. No drain_done; the next cycle has out_valid = 0.
- out_ready held low indefinitely: block stalls, no data loss, overrun still tracked.

Decomposition:
- Shared package ndp_pkg holds:
  - the N_ELEMS and N_WORDS derivation functions;
  - the state encoding (IDLE = 1'b0, STREAM = 1'b1);
  - a clog2 helper for the index width.
- One natural sub-module: ndp_relu_slice (WIDTH-bit element in, MSB-gated zero out, pass-through when disabled), instantiated OUT_WIDTH/WIDTH times at the output mux.

Test Plan:
All scenarios use small parameters: ARR_WIDTH=2, ARR_HEIGHT=2, SYS_WIDTH=2, SYS_HEIGHT=1, giving 8 elements = 4 words.
- Basic drain: in_c elements 0x0001..0x0008, rise calc_done_flag, out_ready=1 → words 0x00020001, 0x00040003, 0x00060005, 0x00080007 on consecutive cycles starting 1 cycle after the edge; out_last on word 3; drain_done pulses the next cycle.
- Backpressure: toggle out_ready 1,0,0,1,... → each word is held stable while stalled; exactly 4 transfers; no duplicates.
- Snapshot isolation: change in_c to all 0xFFFF one cycle after the edge → output still 0x00020001..0x00080007.
- ReLU: APPLY_RELU=1, element 1 = 0xBC00, element 0 = 0x3C00 → word 0 = 0x00003C00.
- Overrun: drop calc_done_flag and re-raise it mid-stream → overrun = 1, stream completes with the original data, no restart.
- Reset mid-stream: assert reset after word 1 → next cycle out_valid = 0, busy = 0, no drain_done. With calc_done_flag held high through release, no new drain starts.
